// File: rtl/ram_input_controller.sv
// Switch/key front end for the 32x4 RAM lab: synchronises raw board inputs, debounces the
// write key into a single one-cycle write, and optionally auto-steps the address for read-back.
module ram_input_controller #(
  parameter int ADDR_W          = 5,
  parameter int DATA_W          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_PERIOD     = 50000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              key_write_n,
  input  logic              sw_scan,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataIn,
  output logic              wren,
  output logic              scan_active,
  output logic [2:0]        dbg_state_o
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SCAN_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);

  // IDLE is encoded as zero so the debug port reads 0 out of reset.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    WRITE    = 3'd2,
    WAIT_REL = 3'd3,
    DB_REL   = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] key_sync_q;
  logic [SYNC_STAGES-1:0] scan_sync_q;
  logic [ADDR_W-1:0]      addr_sync_q [SYNC_STAGES];
  logic [DATA_W-1:0]      data_sync_q [SYNC_STAGES];

  logic              key_s;
  logic              scan_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] data_s;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               wren_q;
  logic [ADDR_W-1:0]  address_q;
  logic [DATA_W-1:0]  data_q;
  logic               scan_active_q;
  logic [SCAN_W-1:0]  scan_cnt_q;

  // Key synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_sync_q  <= '1;
      scan_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_sync_q[i] <= '0;
        data_sync_q[i] <= '0;
      end
    end else begin
      key_sync_q     <= {key_sync_q[SYNC_STAGES-2:0], key_write_n};
      scan_sync_q    <= {scan_sync_q[SYNC_STAGES-2:0], sw_scan};
      addr_sync_q[0] <= sw_addr;
      data_sync_q[0] <= sw_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        addr_sync_q[i] <= addr_sync_q[i-1];
        data_sync_q[i] <= data_sync_q[i-1];
      end
    end
  end

  assign key_s  = key_sync_q[SYNC_STAGES-1];
  assign scan_s = scan_sync_q[SYNC_STAGES-1];
  assign addr_s = addr_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Press/release debouncer: one write per accepted press, then wait for a stable release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wren_q  <= 1'b0;
    end else begin
      wren_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!key_s && !scan_active_q) begin
            state_q <= DB_PRESS;
            cnt_q   <= '0;
          end
        end
        DB_PRESS: begin
          if (key_s || scan_active_q) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= WRITE;
            wren_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WRITE: begin
          state_q <= WAIT_REL;
        end
        WAIT_REL: begin
          if (key_s) begin
            state_q <= DB_REL;
            cnt_q   <= '0;
          end
        end
        DB_REL: begin
          if (!key_s) begin
            state_q <= WAIT_REL;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Address/data hold their WRITE-cycle values for one extra cycle of hold margin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address_q     <= '0;
      data_q        <= '0;
      scan_active_q <= 1'b0;
      scan_cnt_q    <= '0;
    end else begin
      scan_active_q <= scan_s;
      if (!scan_active_q || scan_cnt_q == SCAN_LAST) begin
        scan_cnt_q <= '0;
      end else begin
        scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
      end
      if (state_q != WRITE) begin
        data_q <= data_s;
        if (!scan_active_q) begin
          address_q <= addr_s;
        end else if (scan_cnt_q == SCAN_LAST) begin
          address_q <= address_q + ADDR_W'(1);
        end
      end
    end
  end

  assign address     = address_q;
  assign dataIn      = data_q;
  assign wren        = wren_q;
  assign scan_active = scan_active_q;
  assign dbg_state_o = state_q;

endmodule
